// File: rtl/wb_arb_pkg.sv
// ----------------------------------------------------------------------------
// wb_arb_pkg
// Shared definitions for the two-master Wishbone SRAM arbiter:
//   - arbiter FSM state encodings (ST_IDLE / ST_OWN / ST_ABORT) and the enum
//     built on them
//   - Wishbone B3 cycle-type (CTI) constants
// ----------------------------------------------------------------------------
package wb_arb_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_OWN   = 2'd1;
  localparam logic [1:0] ST_ABORT = 2'd2;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_CONST   = 3'b001;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_END     = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_OWN   = ST_OWN,
    S_ABORT = ST_ABORT
  } arb_state_t;

endpackage

// File: rtl/wb_arb_watchdog.sv
// ----------------------------------------------------------------------------
// wb_arb_watchdog
// Counts consecutive stalled strobe cycles of the current bus owner and flags
// expiry on the TIMEOUT-th stalled cycle.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   run        : owner is strobing the slave (arbiter in OWN, s_stb_o high)
//   resp       : slave answered this cycle (ack | err | rty)
//   expired    : combinational, high during the TIMEOUT-th stalled cycle
// ----------------------------------------------------------------------------
module wb_arb_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic resp,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;
  logic          stall;

  assign stall = run & ~resp;

  // cnt holds the number of stalled cycles already completed, so the current
  // stalled cycle is number cnt+1; it reaches TIMEOUT when cnt == TIMEOUT-1.
  assign expired = stall && (cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!stall || expired) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/wb_ram_arbiter.sv
// ----------------------------------------------------------------------------
// wb_ram_arbiter
// Two-master Wishbone B3 arbiter in front of the single-port on-chip SRAM.
// Master 0 is the CPU instruction bus, master 1 the data/debug bus. Ownership
// is granted per bus cycle (round-robin on ties) and held until the owner
// drops cyc, so bursts and read-modify-write sequences are atomic.
//
// Optional feature macro: ARB_TIMEOUT_EN -- enables a watchdog that signals
// err to the owner after TIMEOUT stalled strobe cycles and aborts the cycle.
//
// Ports:
//   wb_clk_i, wb_rst_n_i     : clock, asynchronous active-low reset
//   m0_*/m1_* inputs         : master request (adr, dat, sel, we, cyc, stb,
//                              cti, bte)
//   m0_*/m1_* dat_o          : slave read data broadcast to both masters
//   m0_*/m1_* ack/err/rty_o  : slave responses, routed to the owner only
//   s_* outputs              : slave request, muxed from the owner
//   s_dat_i/ack/err/rty_i    : slave responses
//   dbg_state                : current arbiter FSM state (ST_* encoding)
//
// Handshake: a transfer completes in any cycle where the owner's cyc and stb
// are high together with one of the slave's ack/err/rty; the arbiter adds no
// registers on this path, so the slave sets the pace in both directions.
// ----------------------------------------------------------------------------
module wb_ram_arbiter
  import wb_arb_pkg::*;
#(
  parameter int dw      = 32,
  parameter int aw      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_n_i,
  // master 0
  input  logic [aw-1:0] m0_adr_i,
  input  logic [dw-1:0] m0_dat_i,
  input  logic [3:0]    m0_sel_i,
  input  logic          m0_we_i,
  input  logic          m0_cyc_i,
  input  logic          m0_stb_i,
  input  logic [2:0]    m0_cti_i,
  input  logic [1:0]    m0_bte_i,
  output logic [dw-1:0] m0_dat_o,
  output logic          m0_ack_o,
  output logic          m0_err_o,
  output logic          m0_rty_o,
  // master 1
  input  logic [aw-1:0] m1_adr_i,
  input  logic [dw-1:0] m1_dat_i,
  input  logic [3:0]    m1_sel_i,
  input  logic          m1_we_i,
  input  logic          m1_cyc_i,
  input  logic          m1_stb_i,
  input  logic [2:0]    m1_cti_i,
  input  logic [1:0]    m1_bte_i,
  output logic [dw-1:0] m1_dat_o,
  output logic          m1_ack_o,
  output logic          m1_err_o,
  output logic          m1_rty_o,
  // slave
  output logic [aw-1:0] s_adr_o,
  output logic [dw-1:0] s_dat_o,
  output logic [3:0]    s_sel_o,
  output logic          s_we_o,
  output logic          s_cyc_o,
  output logic          s_stb_o,
  output logic [2:0]    s_cti_o,
  output logic [1:0]    s_bte_o,
  input  logic [dw-1:0] s_dat_i,
  input  logic          s_ack_i,
  input  logic          s_err_i,
  input  logic          s_rty_i,
  // debug
  output logic [1:0]    dbg_state
);

  arb_state_t state_q, state_d;
  logic       own_q, own_d;    // current owner (0 = master 0, 1 = master 1)
  logic       last_q, last_d;  // previous owner, loses the next tie
  logic       winner;
  logic       o_cyc, o_stb;
  logic       wd_expired;

  assign o_cyc = own_q ? m1_cyc_i : m0_cyc_i;
  assign o_stb = own_q ? m1_stb_i : m0_stb_i;

  // On a tie the master that did not own the bus last wins; otherwise the
  // single requester wins (m1_cyc_i alone selects master 1).
  assign winner = (m0_cyc_i && m1_cyc_i) ? ~last_q : m1_cyc_i;

`ifdef ARB_TIMEOUT_EN
  logic wd_run, wd_resp;

  assign wd_run  = (state_q == S_OWN) && s_stb_o;
  assign wd_resp = s_ack_i | s_err_i | s_rty_i;

  wb_arb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (wb_clk_i),
    .rst_n   (wb_rst_n_i),
    .run     (wd_run),
    .resp    (wd_resp),
    .expired (wd_expired)
  );
`else
  localparam int unused_timeout = TIMEOUT;
  assign wd_expired = 1'b0;
`endif

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q <= S_IDLE;
      own_q   <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      own_q   <= own_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    own_d   = own_q;
    last_d  = last_q;
    case (state_q)
      S_IDLE: begin
        if (m0_cyc_i || m1_cyc_i) begin
          state_d = S_OWN;
          own_d   = winner;
          last_d  = winner;
        end
      end
      S_OWN: begin
        // Release on owner cyc low takes priority; responses never release.
        if (!o_cyc) begin
          state_d = S_IDLE;
        end else if (wd_expired) begin
          state_d = S_ABORT;
        end
      end
      S_ABORT: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    s_adr_o  = '0;
    s_dat_o  = '0;
    s_sel_o  = '0;
    s_we_o   = 1'b0;
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_cti_o  = 3'b000;
    s_bte_o  = 2'b00;
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m0_rty_o = 1'b0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    m1_rty_o = 1'b0;
    if (state_q == S_OWN) begin
      s_adr_o  = own_q ? m1_adr_i : m0_adr_i;
      s_dat_o  = own_q ? m1_dat_i : m0_dat_i;
      s_sel_o  = own_q ? m1_sel_i : m0_sel_i;
      s_we_o   = own_q ? m1_we_i  : m0_we_i;
      s_cti_o  = own_q ? m1_cti_i : m0_cti_i;
      s_bte_o  = own_q ? m1_bte_i : m0_bte_i;
      s_cyc_o  = o_cyc;
      s_stb_o  = o_stb & o_cyc;
      m0_ack_o = ~own_q & s_ack_i;
      m0_err_o = ~own_q & (s_err_i | wd_expired);
      m0_rty_o = ~own_q & s_rty_i;
      m1_ack_o = own_q & s_ack_i;
      m1_err_o = own_q & (s_err_i | wd_expired);
      m1_rty_o = own_q & s_rty_i;
    end
  end

  assign m0_dat_o  = s_dat_i;
  assign m1_dat_o  = s_dat_i;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_wb_ram_arbiter.sv
// ----------------------------------------------------------------------------
// tb_wb_ram_arbiter
// Directed bench for wb_ram_arbiter. Inputs are driven 1 time unit after the
// rising edge; outputs are sampled 2-3 units later, well clear of the edge.
// The watchdog scenario checks the expiry behaviour when ARB_TIMEOUT_EN is
// defined and the hold-forever behaviour otherwise.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_wb_ram_arbiter;
  import wb_arb_pkg::*;

  localparam int DW = 32;
  localparam int AW = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic [AW-1:0] m0_adr, m1_adr;
  logic [DW-1:0] m0_wdat, m1_wdat;
  logic [3:0]    m0_sel, m1_sel;
  logic          m0_we, m0_cyc, m0_stb, m1_we, m1_cyc, m1_stb;
  logic [2:0]    m0_cti, m1_cti;
  logic [1:0]    m0_bte, m1_bte;
  logic [DW-1:0] m0_rdat, m1_rdat;
  logic          m0_ack, m0_err, m0_rty, m1_ack, m1_err, m1_rty;
  logic [AW-1:0] s_adr;
  logic [DW-1:0] s_wdat, s_rdat;
  logic [3:0]    s_sel;
  logic          s_we, s_cyc, s_stb, s_ack, s_err, s_rty;
  logic [2:0]    s_cti;
  logic [1:0]    s_bte;
  logic [1:0]    dbg_state;

  wb_ram_arbiter #(.dw(DW), .aw(AW), .TIMEOUT(8)) dut (
    .wb_clk_i   (clk),
    .wb_rst_n_i (rst_n),
    .m0_adr_i (m0_adr), .m0_dat_i (m0_wdat), .m0_sel_i (m0_sel),
    .m0_we_i  (m0_we),  .m0_cyc_i (m0_cyc),  .m0_stb_i (m0_stb),
    .m0_cti_i (m0_cti), .m0_bte_i (m0_bte),  .m0_dat_o (m0_rdat),
    .m0_ack_o (m0_ack), .m0_err_o (m0_err),  .m0_rty_o (m0_rty),
    .m1_adr_i (m1_adr), .m1_dat_i (m1_wdat), .m1_sel_i (m1_sel),
    .m1_we_i  (m1_we),  .m1_cyc_i (m1_cyc),  .m1_stb_i (m1_stb),
    .m1_cti_i (m1_cti), .m1_bte_i (m1_bte),  .m1_dat_o (m1_rdat),
    .m1_ack_o (m1_ack), .m1_err_o (m1_err),  .m1_rty_o (m1_rty),
    .s_adr_o (s_adr), .s_dat_o (s_wdat), .s_sel_o (s_sel), .s_we_o (s_we),
    .s_cyc_o (s_cyc), .s_stb_o (s_stb),  .s_cti_o (s_cti), .s_bte_o (s_bte),
    .s_dat_i (s_rdat), .s_ack_i (s_ack), .s_err_i (s_err), .s_rty_i (s_rty),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [AW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic bus_quiet();
    m0_adr = '0; m0_wdat = '0; m0_sel = 4'hf; m0_we = 1'b0;
    m0_cyc = 1'b0; m0_stb = 1'b0; m0_cti = CTI_CLASSIC; m0_bte = 2'b00;
    m1_adr = '0; m1_wdat = '0; m1_sel = 4'hf; m1_we = 1'b0;
    m1_cyc = 1'b0; m1_stb = 1'b0; m1_cti = CTI_CLASSIC; m1_bte = 2'b00;
    s_rdat = '0; s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    bus_quiet();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #5;
    rst_n = 1'b1;
  endtask

  // Overall time bound in case the stimulus ever stalls.
  initial begin
    #200000;
    $display("FAIL time_limit: got timeout expected completion");
    $fatal(1, "time limit");
  end

  logic [AW-1:0] base;

  initial begin
    bus_quiet();

    // ---- 1: reset state and single read by master 0 ----
    reset_dut();
    check("rst_state", dbg_state, ST_IDLE);
    check("rst_s_cyc", s_cyc, 1'b0);
    check("rst_s_adr", s_adr, 32'h0);
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 32'h100;
    #2;
    check("rd_idle_cyc", s_cyc, 1'b0);
    tick();                                   // cycle 1
    #2;
    check("rd_c1_cyc", s_cyc, 1'b1);
    check("rd_c1_adr", s_adr, 32'h100);
    check("rd_c1_ack", m0_ack, 1'b0);
    tick();                                   // cycle 2: slave acks
    s_ack = 1'b1; s_rdat = 32'hdead_beef;
    #2;
    check("rd_c2_m0ack", m0_ack, 1'b1);
    check("rd_c2_m1ack", m1_ack, 1'b0);
    check("rd_c2_data", m0_rdat, 32'hdead_beef);
    tick();                                   // cycle 3: master drops cyc
    s_ack = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0;
    #2;
    check("rd_rel_cyc", s_cyc, 1'b0);
    tick();
    #2;
    check("rd_rel_state", dbg_state, ST_IDLE);

    // ---- 2: tie arbitration and round-robin ----
    reset_dut();
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 32'h1000;
    m1_cyc = 1'b1; m1_stb = 1'b1; m1_adr = 32'h2000;
    tick();                                   // cycle 1: master 0 owns
    #2;
    check("tie1_state", dbg_state, ST_OWN);
    check("tie1_adr", s_adr, 32'h1000);
    s_ack = 1'b1;
    #1;
    check("tie1_m0ack", m0_ack, 1'b1);
    check("tie1_m1ack", m1_ack, 1'b0);
    tick();                                   // cycle 2: master 0 drops
    s_ack = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0;
    #2;
    check("tie_drop_cyc", s_cyc, 1'b0);
    tick();                                   // cycle 3: dead cycle
    #2;
    check("tie_dead_state", dbg_state, ST_IDLE);
    check("tie_dead_cyc", s_cyc, 1'b0);
    tick();                                   // cycle 4: master 1 owns
    #2;
    check("tie_m1_cyc", s_cyc, 1'b1);
    check("tie_m1_adr", s_adr, 32'h2000);
    tick();
    m1_cyc = 1'b0; m1_stb = 1'b0;
    tick();                                   // IDLE: new tie
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 32'h1004;
    m1_cyc = 1'b1; m1_stb = 1'b1; m1_adr = 32'h2004;
    tick();
    #2;
    check("tie2_adr", s_adr, 32'h1004);
    tick();
    m0_cyc = 1'b0; m0_stb = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
    tick();

    // ---- 3: master 1 wrap-4 burst while master 0 waits ----
    // last owner is master 0, so master 1 wins this tie.
    exp_q = '{32'h0c, 32'h00, 32'h04, 32'h08};
    base  = 32'h0c;
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 32'h1008;
    m1_cyc = 1'b1; m1_stb = 1'b1; m1_adr = base;
    m1_cti = CTI_INCR; m1_bte = 2'b01;
    tick();                                   // cycle 1: burst starts
    for (int b = 0; b < 4; b++) begin
      m1_adr = {base[AW-1:4], 2'(base[3:2] + 2'(b)), 2'b00};
      m1_cti = (b == 3) ? CTI_END : CTI_INCR;
      s_ack = 1'b1; s_rdat = 32'h5a00_0000 + 32'(b);
      #2;
      check($sformatf("burst%0d_m1ack", b), m1_ack, 1'b1);
      check($sformatf("burst%0d_m0ack", b), m0_ack, 1'b0);
      check($sformatf("burst%0d_adr", b), s_adr, exp_q.pop_front());
      check($sformatf("burst%0d_cti", b), s_cti, (b == 3) ? 3'b111 : 3'b010);
      tick();
    end
    s_ack = 1'b0; m1_stb = 1'b0; m1_cti = CTI_CLASSIC;   // cyc still high
    #2;
    check("burst_hold_state", dbg_state, ST_OWN);
    check("burst_hold_cyc", s_cyc, 1'b1);
    check("burst_hold_adr", s_adr, 32'h08);
    tick();
    m1_cyc = 1'b0; m1_bte = 2'b00;
    tick();
    #2;
    check("burst_rel_state", dbg_state, ST_IDLE);
    tick();
    #2;
    check("burst_m0_adr", s_adr, 32'h1008);
    check("burst_m0_cyc", s_cyc, 1'b1);
    tick();
    m0_cyc = 1'b0; m0_stb = 1'b0;
    tick();

    // ---- 4: reset pulse in beat 2 of a master 0 burst ----
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 32'h200; m0_cti = CTI_INCR;
    tick();                                   // beat 1
    s_ack = 1'b1;
    #2;
    check("rstb_beat1_ack", m0_ack, 1'b1);
    tick();                                   // beat 2
    m0_adr = 32'h204; m1_cyc = 1'b1; m1_stb = 1'b1; m1_adr = 32'h404;
    #1;
    rst_n = 1'b0;
    #1;
    check("rstb_cyc", s_cyc, 1'b0);
    check("rstb_m0ack", m0_ack, 1'b0);
    check("rstb_m1ack", m1_ack, 1'b0);
    check("rstb_state", dbg_state, ST_IDLE);
    @(posedge clk);
    #5;
    rst_n = 1'b1; s_ack = 1'b0;
    #1;
    check("rstb_post_state", dbg_state, ST_IDLE);
    tick();                                   // tie after reset -> master 0
    #2;
    check("rstb_regrant_state", dbg_state, ST_OWN);
    check("rstb_regrant_adr", s_adr, 32'h204);
    m0_cyc = 1'b0; m0_stb = 1'b0; m0_cti = CTI_CLASSIC;
    m1_cyc = 1'b0; m1_stb = 1'b0;
    tick();
    tick();

    // ---- 5: slave never answers master 0 ----
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 32'h300;
    tick();                                   // stalled cycle 1
    m1_cyc = 1'b1; m1_stb = 1'b1; m1_adr = 32'h400;
    for (int k = 1; k < 8; k++) begin
      #2;
      check($sformatf("wd_stall%0d_err", k), m0_err, 1'b0);
      tick();
    end
    // stalled cycle 8
    #2;
`ifdef ARB_TIMEOUT_EN
    check("wd_expire_m0err", m0_err, 1'b1);
    check("wd_expire_m1err", m1_err, 1'b0);
    tick();
    #2;
    check("wd_abort_state", dbg_state, ST_ABORT);
    check("wd_abort_cyc", s_cyc, 1'b0);
    check("wd_abort_stb", s_stb, 1'b0);
    tick();
    #2;
    check("wd_idle_state", dbg_state, ST_IDLE);
    tick();
    #2;
    check("wd_m1_state", dbg_state, ST_OWN);
    check("wd_m1_adr", s_adr, 32'h400);
`else
    check("wd_off_m0err8", m0_err, 1'b0);
    for (int k = 9; k < 14; k++) begin
      tick();
      #2;
      check($sformatf("wd_off_err%0d", k), m0_err, 1'b0);
    end
    check("wd_off_state", dbg_state, ST_OWN);
    check("wd_off_adr", s_adr, 32'h300);
    check("wd_off_cyc", s_cyc, 1'b1);
`endif
    tick();
    bus_quiet();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_ram_arbiter.md
# wb_ram_arbiter

Two-master Wishbone B3 arbiter that shares the single-port on-chip SRAM slave between the CPU instruction bus (master 0) and the data/debug bus (master 1). It grants ownership per bus cycle, holds the grant for the whole cycle including registered-feedback bursts (cti 001/010 until 111), and muxes address, control and data between the winning master and the slave. An optional watchdog aborts a cycle the slave never completes.

## Interface
Parameters:
- dw, 32, data width
- aw, 32, address width
- TIMEOUT, 255, watchdog limit in cycles; only used when ARB_TIMEOUT_EN is defined; must be ≥ 2

Ports (the `m0_`/`m1_` lines are one port per master):
- wb_clk_i  in  1  clock
- wb_rst_n_i  in  1  reset, asynchronous assert, active-low
- m0_/m1_ adr_i  in  aw  master address
- m0_/m1_ dat_i  in  dw  master write data
- m0_/m1_ sel_i  in  4  byte selects
- m0_/m1_ we_i, cyc_i, stb_i  in  1 each  Wishbone controls
- m0_/m1_ cti_i  in  3  cycle type
- m0_/m1_ bte_i  in  2  burst type
- m0_/m1_ dat_o  out  dw  read data (s_dat_i broadcast to both masters)
- m0_/m1_ ack_o, err_o, rty_o  out  1 each  gated to the owner only
- s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o, s_cti_o, s_bte_o  out  slave side, muxed from the owner
- s_dat_i, s_ack_i, s_err_i, s_rty_i  in  slave responses

## Operation
- FSM states: IDLE, OWN, ABORT. The owner register `own` is 0 or 1. The `last` register holds the previous owner.
- IDLE:
  - If exactly one `mN_cyc_i` is high, grant that master.
  - If both are high, grant the master that is not `last` (round-robin).
  - On a grant: `own` ← winner, `last` ← winner, go to OWN.
- OWN:
  - `s_*` outputs = owner's `m*_*` inputs, combinationally.
  - Owner's ack/err/rty = `s_ack_i`/`s_err_i`/`s_rty_i`.
  - Non-owner ack/err/rty = 0. Non-owner stb/cyc are ignored.
- Release: when the owner's cyc_i is low in OWN, go to IDLE. `s_cyc_o` drops in the same cycle, combinationally.
  - Grant is never changed while the owner's cyc_i is high. Bursts and RMW sequences are therefore atomic.
  - A burst ended by cti=111 with ack, while cyc stays high, keeps the grant.
- ABORT: see Configuration. `s_cyc_o` = `s_stb_o` = 0. Lasts one cycle, then IDLE.
- IDLE and ABORT outputs: s_cyc_o, s_stb_o, s_we_o = 0; s_adr_o, s_dat_o = 0; s_sel_o = 0; s_cti_o = 000; s_bte_o = 00; all master ack/err/rty = 0.
- Reset (asynchronous, wb_rst_n_i = 0):
  - State = IDLE, `own` = 0, `last` = 1, so master 0 wins the first tie.
  - Watchdog counter = 0. All outputs take their IDLE values.
- Reset asserted mid-burst: the grant is lost immediately, `s_cyc_o` goes to 0 and no ack reaches either master.
- Error and retry responses do not release the grant. Only cyc_i low or the watchdog releases it.

## Timing
- Arbitration latency is one cycle. A request in IDLE in cycle N gives OWN with `s_cyc_o` high in cycle N+1.
- Handover costs one dead cycle minimum. Owner cyc low in N → IDLE in N+1 → new owner in N+2.
- Slave responses pass to the owner combinationally, with no added latency. A burst keeps the slave's one-ack-per-cycle rate.
- Both masters requesting continuously alternate grants cycle-by-cycle of ownership, with no starvation.

## Configuration
- ARB_TIMEOUT_EN defined:
  - A counter of width clog2(TIMEOUT+1) increments each OWN cycle where `s_stb_o` = 1 and `s_ack_i`, `s_err_i`, `s_rty_i` are all 0.
  - It clears on any response or when stb is low.
  - When it reaches TIMEOUT: the owner's err_o is 1 for that cycle, the FSM goes to ABORT, then to IDLE, and the counter clears.
- ARB_TIMEOUT_EN undefined: no counter and no ABORT transition. The FSM reduces to IDLE/OWN. Counter logic and the TIMEOUT parameter have no effect.

## Structure
- Shared package `wb_arb_pkg`:
  - State encoding constants ST_IDLE=2'd0, ST_OWN=2'd1, ST_ABORT=2'd2.
  - CTI constants CTI_CLASSIC=3'b000, CTI_CONST=3'b001, CTI_INCR=3'b010, CTI_END=3'b111.
- One sub-module, `wb_arb_watchdog`: counter, clear and expiry flag. It is instantiated only under ARB_TIMEOUT_EN.
- The mux and FSM stay in the top module.

## Test plan
- After reset, master 0 issues a single read of 0x100 while the slave acks in cycle 2 → `s_cyc_o` high from cycle 1, `m0_ack_o` high in cycle 2, `m1_ack_o` stays 0.
- Both masters assert cyc in the same cycle → master 0 is granted first. Master 1 is granted 2 cycles after master 0 drops cyc. On the next simultaneous tie, master 1 is not re-granted first.
- Master 1 runs a 4-beat incrementing burst (bte=01, cti 010,010,010,111) from 0x0C while master 0 requests → four consecutive acks to master 1 with no grant change. Master 0 is granted only after master 1 drops cyc.
- wb_rst_n_i is pulsed low during beat 2 of a burst → `s_cyc_o` and every ack go to 0 asynchronously. After release, `last` = 1 and a tie grants master 0.
- With ARB_TIMEOUT_EN defined and TIMEOUT=8, the slave never acks master 0's stb → `m0_err_o` is high in the 8th stalled cycle. The next cycle is ABORT with `s_cyc_o` = 0, then a pending master 1 is granted.
- With the macro undefined, the same stimulus leaves master 0 owning indefinitely and `m0_err_o` stays 0.
